// File: rtl/ad7265_responder.sv
// AD7265-style dual serial ADC responder: two 6x12-bit tables shifted out MSB-first on douta/doutb.
// Optional build macro AD7265_RESPONDER_RAMP_EN: each completed frame increments the table entries it used.
module ad7265_responder (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        adc_sclk_en,
   input  logic        ncs,
   input  logic [2:0]  adc_addr,
   input  logic        sgl,
   input  logic        rng,
   input  logic        wr_en,
   input  logic        wr_ch,
   input  logic [2:0]  wr_idx,
   input  logic [11:0] wr_data,
   output logic        douta,
   output logic        doutb,
   output logic        dout_oe,
   output logic [15:0] frame_count,
   output logic        last_sgl,
   output logic        last_rng,
   output logic        short_frame,
   input  logic        short_clr
);

   typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

   state_t      state, state_next;
   logic        ncs_q;
   logic [3:0]  bit_cnt;
   logic [15:0] sh_a, sh_b;
   logic [2:0]  frame_addr;
   logic [11:0] tab_a [6];
   logic [11:0] tab_b [6];
   logic [11:0] load_a, load_b;
   logic        start, step, to_tail, complete, abort;

   assign load_a = (adc_addr < 3'd6) ? tab_a[adc_addr] : 12'h000;
   assign load_b = (adc_addr < 3'd6) ? tab_b[adc_addr] : 12'h000;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
   always_comb begin
      state_next = state;
      start      = 1'b0;
      step       = 1'b0;
      to_tail    = 1'b0;
      complete   = 1'b0;
      abort      = 1'b0;
      unique case (state)
         IDLE: begin
            if (!ncs && ncs_q) begin
               start      = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT, TAIL: begin
            if (ncs) begin
               state_next = IDLE;
               if (bit_cnt >= 4'd13) complete = 1'b1;
               else                  abort    = 1'b1;
            end else if (state == SHIFT && adc_sclk_en) begin
               if (bit_cnt == 4'd15) begin
                  to_tail    = 1'b1;
                  state_next = TAIL;
               end else begin
                  step = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Shift words are captured at frame start, so table writes mid-frame never disturb the frame in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ncs_q       <= 1'b0;
         bit_cnt     <= '0;
         sh_a        <= '0;
         sh_b        <= '0;
         frame_addr  <= '0;
         douta       <= 1'b0;
         doutb       <= 1'b0;
         dout_oe     <= 1'b0;
         frame_count <= '0;
         last_sgl    <= 1'b0;
         last_rng    <= 1'b0;
         short_frame <= 1'b0;
      end else begin
         ncs_q <= ncs;
         if (start) begin
            frame_addr <= adc_addr;
            last_sgl   <= sgl;
            last_rng   <= rng;
            sh_a       <= {2'b00, load_a, 2'b00};
            sh_b       <= {2'b00, load_b, 2'b00};
            bit_cnt    <= '0;
            dout_oe    <= 1'b1;
            douta      <= 1'b0;
            doutb      <= 1'b0;
         end
         if (step) begin
            bit_cnt <= bit_cnt + 4'd1;
            douta   <= sh_a[14];
            doutb   <= sh_b[14];
            sh_a    <= {sh_a[14:0], 1'b0};
            sh_b    <= {sh_b[14:0], 1'b0};
         end
         if (to_tail) begin
            douta <= 1'b0;
            doutb <= 1'b0;
         end
         if (complete || abort) begin
            dout_oe <= 1'b0;
            douta   <= 1'b0;
            doutb   <= 1'b0;
         end
         if (complete) frame_count <= frame_count + 16'd1;
         if (abort)          short_frame <= 1'b1;
         else if (short_clr) short_frame <= 1'b0;
      end
   end

   // NOTE: the tables are reset like any other state because a known all-zero content is required after reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 6; i++) begin
            tab_a[i] <= '0;
            tab_b[i] <= '0;
         end
      end else begin
`ifdef AD7265_RESPONDER_RAMP_EN
         if (complete && frame_addr < 3'd6) begin
            tab_a[frame_addr] <= tab_a[frame_addr] + 12'd1;
            tab_b[frame_addr] <= tab_b[frame_addr] + 12'd1;
         end
`endif
         // NOTE: non-blocking assignments; the later write to the same entry wins, giving wr_en priority over the ramp.
         if (wr_en && wr_idx < 3'd6) begin
            if (wr_ch) tab_b[wr_idx] <= wr_data;
            else       tab_a[wr_idx] <= wr_data;
         end
      end
   end

endmodule
